// File: rtl/deadlock_block_collector.sv
// Deadlock block collector.
//
// Collects the `block` flags of the per-process deadlock monitors and
// confirms a deadlock once the same non-zero blocked pattern has been seen
// on CONFIRM_CYCLES consecutive rising edges. A confirmed deadlock latches a
// one-shot report that is offered over a valid/ready handshake. The report
// holds the offending mask and the lowest blocked index. The collector then
// stays sticky until `clear` re-arms it.
//
// all_idle masks the flags: a fully idle region is normal completion.
//
// Ports:
//   clock         sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   mon_block     registered block flags, one per monitored process
//   all_idle      whole dataflow region idle (suppresses mon_block)
//   clear         single-cycle pulse, re-arms the collector
//   report_valid  report available
//   report_ready  consumer accepts the report
//   report_mask   blocked mask latched at confirmation
//   report_idx    lowest set bit of report_mask
//   deadlock      sticky confirmed-deadlock flag
//   stall_count   current consecutive-stall count (saturates at CONFIRM_CYCLES)

module deadlock_block_collector #(
    parameter int unsigned NUM_MON        = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned CONFIRM_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               all_idle,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [NUM_MON-1:0] report_mask,
    output logic [IDX_W-1:0]   report_idx,
    output logic               deadlock,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [CNT_W-1:0] CountLast = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CountFull = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] CountOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSuspect,
        StReport,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_MON-1:0] prev_mask_q, prev_mask_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [NUM_MON-1:0] report_mask_q, report_mask_d;
    logic [IDX_W-1:0]   report_idx_q, report_idx_d;
    logic               report_valid_q, report_valid_d;
    logic               deadlock_q, deadlock_d;

    logic [NUM_MON-1:0] eff_mask;

    // Index of the lowest set bit; 0 for an all-zero mask.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign eff_mask = all_idle ? '0 : mon_block;

    always_comb begin
        state_d        = state_q;
        prev_mask_d    = prev_mask_q;
        stall_count_d  = stall_count_q;
        report_mask_d  = report_mask_q;
        report_idx_d   = report_idx_q;
        report_valid_d = report_valid_q;
        deadlock_d     = deadlock_q;

        if (clear) begin
            // Report fields are kept for post-mortem reads.
            state_d        = StIdle;
            prev_mask_d    = '0;
            stall_count_d  = '0;
            report_valid_d = 1'b0;
            deadlock_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    prev_mask_d = eff_mask;
                    if (eff_mask != '0) begin
                        state_d       = StSuspect;
                        stall_count_d = CountOne;
                    end else begin
                        stall_count_d = '0;
                    end
                end

                StSuspect: begin
                    prev_mask_d = eff_mask;
                    if (eff_mask == '0) begin
                        state_d       = StIdle;
                        stall_count_d = '0;
                    end else if (eff_mask != prev_mask_q) begin
                        // Pattern changed: restart the debounce window.
                        stall_count_d = CountOne;
                    end else if (stall_count_q == CountLast) begin
                        state_d        = StReport;
                        stall_count_d  = CountFull;
                        report_mask_d  = eff_mask;
                        report_idx_d   = lowest_set(eff_mask);
                        report_valid_d = 1'b1;
                        deadlock_d     = 1'b1;
                    end else begin
                        stall_count_d = stall_count_q + CountOne;
                    end
                end

                StReport: begin
                    if (report_ready) begin
                        report_valid_d = 1'b0;
                        state_d        = StHalt;
                    end
                end

                StHalt: begin
                    // Sticky until clear or reset.
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            prev_mask_q    <= '0;
            stall_count_q  <= '0;
            report_mask_q  <= '0;
            report_idx_q   <= '0;
            report_valid_q <= 1'b0;
            deadlock_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_mask_q    <= prev_mask_d;
            stall_count_q  <= stall_count_d;
            report_mask_q  <= report_mask_d;
            report_idx_q   <= report_idx_d;
            report_valid_q <= report_valid_d;
            deadlock_q     <= deadlock_d;
        end
    end

    assign report_valid = report_valid_q;
    assign report_mask  = report_mask_q;
    assign report_idx   = report_idx_q;
    assign deadlock     = deadlock_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_deadlock_block_collector.sv
// Bench for deadlock_block_collector with CONFIRM_CYCLES=8.
// A run-length reference model predicts each cycle's outputs and pushes
// expected reports into a queue; the negedge monitor compares them.

module tb_deadlock_block_collector;

    localparam int NM   = 4;
    localparam int CONF = 8;

    logic          clock;
    logic          reset_n;
    logic [NM-1:0] mon_block;
    logic          all_idle;
    logic          clear;
    logic          report_valid;
    logic          report_ready;
    logic [NM-1:0] report_mask;
    logic [1:0]    report_idx;
    logic          deadlock;
    logic [3:0]    stall_count;

    int checks   = 0;
    int failures = 0;

    deadlock_block_collector #(
        .NUM_MON       (NM),
        .IDX_W         (2),
        .CONFIRM_CYCLES(CONF),
        .CNT_W         (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mon_block   (mon_block),
        .all_idle    (all_idle),
        .clear       (clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_mask (report_mask),
        .report_idx  (report_idx),
        .deadlock    (deadlock),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Armed: count how many consecutive edges carried the same non-zero
    // effective mask; at CONF a report is due. Reported: ignore the flags.
    int            m_run;
    logic [NM-1:0] m_last;
    bit            m_armed;
    bit            m_valid;
    bit            m_dead;
    logic [NM-1:0] m_mask;
    logic [1:0]    m_idx;
    logic [5:0]    exp_q[$];
    int            n_pushed;

    function automatic logic [1:0] low_idx(input logic [NM-1:0] m);
        for (int i = 0; i < NM; i++) begin
            if (m[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic [NM-1:0] eff;
        if (!reset_n) begin
            m_run   = 0;
            m_last  = '0;
            m_armed = 1'b1;
            m_valid = 1'b0;
            m_dead  = 1'b0;
            m_mask  = '0;
            m_idx   = '0;
            exp_q.delete();
        end else begin
            eff = all_idle ? '0 : mon_block;
            if (clear) begin
                // A pending report not taken on this edge is discarded.
                if (m_valid && !report_ready && exp_q.size() > 0) void'(exp_q.pop_back());
                m_run   = 0;
                m_last  = '0;
                m_armed = 1'b1;
                m_valid = 1'b0;
                m_dead  = 1'b0;
            end else if (m_armed) begin
                if (eff == '0) m_run = 0;
                else if (m_run > 0 && eff == m_last) m_run = m_run + 1;
                else m_run = 1;
                m_last = eff;
                if (m_run == CONF) begin
                    m_armed = 1'b0;
                    m_valid = 1'b1;
                    m_dead  = 1'b1;
                    m_mask  = eff;
                    m_idx   = low_idx(eff);
                    exp_q.push_back({eff, low_idx(eff)});
                    n_pushed++;
                end
            end else if (m_valid && report_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int n_reports = 0;

    always @(negedge clock) begin
        logic [5:0] head;
        if (reset_n) begin
            check("stall_count", int'(stall_count), m_run);
            check("deadlock", int'(deadlock), int'(m_dead));
            check("report_valid", int'(report_valid), int'(m_valid));
            check("held_mask", int'(report_mask), int'(m_mask));
            check("held_idx", int'(report_idx), int'(m_idx));
            if (report_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_report: got mask %b with no report expected", report_mask);
                end else begin
                    head = exp_q[0];
                    check("report_mask", int'(report_mask), int'(head[5:2]));
                    check("report_idx", int'(report_idx), int'(head[1:0]));
                    check("idx_range", int'(report_idx < 2'(NM - 1) || report_idx == 2'(NM - 1)), 1);
                    if (report_ready) begin
                        void'(exp_q.pop_front());
                        n_reports++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [NM-1:0] mb, input logic ai, input logic clr,
                        input logic rdy);
        @(posedge clock);
        #2;
        mon_block    = mb;
        all_idle     = ai;
        clear        = clr;
        report_ready = rdy;
    endtask

    task automatic hold(input logic [NM-1:0] mb, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(mb, 1'b0, 1'b0, rdy);
    endtask

    task automatic rearm();
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int            left;
        logic [NM-1:0] rmask;

        mon_block    = '0;
        all_idle     = 1'b0;
        clear        = 1'b0;
        report_ready = 1'b0;
        reset_n      = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_valid", int'(report_valid), 0);
        check("rst_dead", int'(deadlock), 0);
        check("rst_count", int'(stall_count), 0);
        check("rst_mask", int'(report_mask), 0);
        check("rst_idx", int'(report_idx), 0);
        #10 reset_n = 1'b1;

        // 1: single held pattern, consumer always ready.
        hold(4'b0100, 12, 1'b1);
        check("t1_sticky", int'(deadlock), 1);

        // 2: pattern change restarts the debounce.
        rearm();
        hold(4'b0110, 5, 1'b1);
        hold(4'b0010, 10, 1'b1);

        // 3: all_idle knocks the count back to zero.
        rearm();
        hold(4'b1000, 6, 1'b1);
        step(4'b1000, 1'b1, 1'b0, 1'b1);
        hold(4'b1000, 4, 1'b1);

        // 4: backpressure for 10 cycles with the flags toggling.
        rearm();
        hold(4'b1010, 8, 1'b0);
        for (int i = 0; i < 10; i++) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        hold(4'b0011, 3, 1'b1);

        // 5: clear in HALT, second report on bit 0.
        rearm();
        hold(4'b0001, 10, 1'b1);

        // clear coinciding with the handshake.
        rearm();
        hold(4'b0101, 9, 1'b0);
        step(4'b0101, 1'b0, 1'b1, 1'b1);
        hold(4'b0000, 2, 1'b1);

        // clear coinciding with the confirming edge: no report.
        hold(4'b1100, 7, 1'b1);
        step(4'b1100, 1'b0, 1'b1, 1'b1);
        hold(4'b1100, 3, 1'b1);
        rearm();

        // 6: asynchronous reset while a report is pending.
        hold(4'b0001, 9, 1'b0);
        check("t6_pending", int'(report_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_valid", int'(report_valid), 0);
        check("t6_dead", int'(deadlock), 0);
        check("t6_count", int'(stall_count), 0);
        check("t6_mask", int'(report_mask), 0);
        check("t6_idx", int'(report_idx), 0);
        mon_block = '0;
        #15 reset_n = 1'b1;
        hold(4'b0000, 4, 1'b1);

        // Random phase.
        left = 0;
        rmask = '0;
        for (int c = 0; c < 3000; c++) begin
            if (left == 0) begin
                rmask = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
                left  = $urandom_range(1, 12);
            end
            left--;
            step(rmask, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)));
        end

        hold(4'b0000, 3, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        check("reports_seen_nonzero", int'(n_reports > 5), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deadlock_block_collector.md
Name: deadlock_block_collector

Overview:
- Receiving end of the per-process deadlock monitors' `block` outputs in the pfb_multichannel simulation harness.
- Gathers NUM_MON monitor flags and debounces them over CONFIRM_CYCLES cycles.
- When a blocked pattern persists that long, it confirms a deadlock and latches a one-shot report (offending mask plus lowest blocked index).
- The report is delivered over a valid/ready handshake to the testbench reporter, and the collector stays sticky until cleared.

Parameters:
- NUM_MON, 4, number of monitor block inputs (one per dataflow process, e.g. write_outputs_U0).
- IDX_W, 2, width of report_idx; must satisfy 2^IDX_W >= NUM_MON.
- CONFIRM_CYCLES, 1024, consecutive cycles of identical non-zero mask required to confirm; must be >= 2.
- CNT_W, 11, stall counter width; must satisfy 2^CNT_W > CONFIRM_CYCLES.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mon_block  in  NUM_MON  registered block flags from the per-process monitors.
- all_idle  in  1  whole dataflow region idle; this is normal completion, not deadlock.
- clear  in  1  single-cycle pulse that re-arms the collector.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts the report.
- report_mask  out  NUM_MON  mask latched at confirmation.
- report_idx  out  IDX_W  lowest set bit of report_mask.
- deadlock  out  1  sticky flag for a confirmed deadlock.
- stall_count  out  CNT_W  current consecutive-stall count.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - report_valid=0, report_mask=0, report_idx=0, deadlock=0, stall_count=0.
  - Internal prev_mask=0.
- Masking: eff_mask = all_idle ? 0 : mon_block. Sampled every rising edge; prev_mask <= eff_mask each edge in IDLE and SUSPECT.
- IDLE:
  - eff_mask!=0: go to SUSPECT, stall_count<=1.
  - Otherwise stay in IDLE, stall_count<=0.
- SUSPECT:
  - eff_mask==0: go to IDLE, stall_count<=0.
  - eff_mask!=prev_mask (still non-zero): stay in SUSPECT, stall_count<=1 (restart debounce).
  - eff_mask==prev_mask and stall_count==CONFIRM_CYCLES-1: go to REPORT and, on that edge:
    - stall_count<=CONFIRM_CYCLES;
    - report_mask<=eff_mask;
    - report_idx<=lowest set bit index of eff_mask;
    - report_valid<=1;
    - deadlock<=1.
  - Otherwise stall_count<=stall_count+1.
- Latency: a constant non-zero mask first sampled at edge E0 makes report_valid=1 after edge E0+(CONFIRM_CYCLES-1), i.e. on the CONFIRM_CYCLES-th sampling edge.
- REPORT:
  - report_valid stays 1 and report_mask/report_idx are held stable until report_valid&&report_ready is sampled.
  - On that handshake edge: report_valid<=0, go to HALT.
  - mon_block and all_idle are ignored.
- HALT:
  - deadlock=1, report fields held, stall_count frozen.
  - Inputs are ignored; only clear or reset leaves this state.
- clear (highest priority after reset, any state):
  - Next state=IDLE.
  - report_valid<=0, deadlock<=0, stall_count<=0, prev_mask<=0.
  - report_mask and report_idx are held, for post-mortem reads.
  - clear in the same cycle as a handshake: clear wins and no second report is produced.
  - clear in the same cycle as the confirming condition in SUSPECT: clear wins and no report is made.
- Saturation: stall_count never exceeds CONFIRM_CYCLES.
- Exactly one report is produced per confirmation.
- reset_n asserted mid-handshake: report_valid drops asynchronously; the report is lost by design.
- report_idx range: always < NUM_MON whenever report_valid=1.

Test Plan:
1. CONFIRM_CYCLES=8; hold mon_block=4'b0100 from edge 0; report_ready=1 -> report_valid high for exactly 1 cycle, starting after edge 7; report_mask=4'b0100; report_idx=2; deadlock=1 and stays 1.
2. mon_block=4'b0110 for 5 edges, then 4'b0010 for 8 edges -> stall_count goes 1..5, 1..7, then report after the 8th 0010 edge; report_idx=1, report_mask=4'b0010.
3. mon_block=4'b1000 held; all_idle pulses 1 at stall_count=6 -> state returns to IDLE, stall_count=0, no report; the count then restarts from 1.
4. Confirm with report_ready=0 for 10 cycles, then 1 -> report_valid held with a stable mask/idx for 10 cycles, drops after the handshake edge; mon_block toggling meanwhile has no effect.
5. In HALT, pulse clear -> deadlock=0, stall_count=0, report_mask retained; re-applying 4'b0001 for 8 edges produces a second report with idx=0.
6. Assert reset_n=0 asynchronously between edges while report_valid=1 -> all outputs 0 immediately; after release with mon_block=0, outputs remain 0.
